// File: rtl/ex_div.sv
// ex_div: iterative restoring divider for the EX stage (MIPS DIV/DIVU).
// It produces one quotient bit per cycle: WIDTH iterations, then one result
// cycle. While it works it holds the pipeline by raising stall_o.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start_i           request a divide (sampled only in IDLE)
//   signed_i          1 = DIV (two's complement), 0 = DIVU
//   dividend_i        dividend (rs)
//   divisor_i         divisor (rt)
//   cancel_i          pipeline flush: abort the current or pending divide
//   hi_o / lo_o       remainder / quotient, registered, held between results
//   ready_o           one-cycle pulse, asserted while hi_o/lo_o are new
//   stall_o           pipeline hold request
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             ready_o,
  output logic             stall_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  // Operand magnitudes: only signed divides with a set MSB get negated.
  always_comb begin
    a_neg = signed_i & dividend_i[WIDTH-1];
    b_neg = signed_i & divisor_i[WIDTH-1];
    a_mag = a_neg ? -dividend_i : dividend_i;
    b_mag = b_neg ? -divisor_i  : divisor_i;
  end

  // One restoring step. The partial remainder is shifted into WIDTH+1 bits
  // because it can exceed WIDTH bits before the trial subtraction when the
  // divisor is large. rem < divisor keeps the trial's MSB a valid sign.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !cancel_i) begin
          if (divisor_i == '0) begin
            // Divide-by-zero: fixed result, no iterations.
            lo_d    = '1;
            hi_d    = dividend_i;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            // Last step: sign-correct straight into the result registers.
            lo_d    = qneg_q ? -quo_nx : quo_nx;
            hi_d    = rneg_q ? -rem_nx : rem_nx;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign ready_o = (state_q == DONE);
  // Stall is raised in the request cycle itself so EX holds the divide;
  // it falls in DONE, releasing the pipeline as the result appears.
  assign stall_o = !rst && (((state_q == IDLE) && start_i && !cancel_i) ||
                            (state_q == BUSY));

endmodule
